ir_queue: RTL and testbench

//  Parametrised instruction register queue; successor to the single-entry IR/AC latch.
//  - Captures instruction words from the data bus into a DEPTH-entry circular buffer.
//  - Presents the decoded fields of the head entry to the microsequencer: opcode, AC, I, X, Y.
//  - Lets the CPU prefetch ahead of execution and discard queued words on a branch or trap.

---
 rtl/ks10_ir_pkg.sv | 20 ++
 rtl/ir_field_split.sv | 16 +
 rtl/ir_queue.sv | 130 +++++++++++++
 tb/tb_ir_queue.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ks10_ir_pkg.sv
// Shared field layout for the instruction register queue.
// Words are numbered big-endian: bit 0 is the MSB, i.e. vector index WIDTH-1.
package ks10_ir_pkg;

  localparam int IR_WIDTH   = 36;
  localparam int IR_OPW     = 9;
  localparam int IR_ACW     = 4;
  localparam int IR_XRW     = 4;
  localparam int IR_IND_OFS = IR_OPW + IR_ACW;
  localparam int IR_YW      = IR_WIDTH - (IR_OPW + IR_ACW + 1 + IR_XRW);

  typedef struct packed {
    logic [IR_OPW-1:0] op;
    logic [IR_ACW-1:0] ac;
    logic              ind;
    logic [IR_XRW-1:0] xr;
    logic [IR_YW-1:0]  y;
  } ir_fields_t;

endpackage

// File: rtl/ir_field_split.sv
// Combinational splitter: instruction word -> opcode/AC/I/X/Y fields.
// Big-endian bit b of the word lives at vector index IR_WIDTH-1-b.
module ir_field_split
  import ks10_ir_pkg::*;
(
  input  logic [IR_WIDTH-1:0] word,
  output ir_fields_t          fields
);

  assign fields.op  = word[IR_WIDTH-1 -: IR_OPW];
  assign fields.ac  = word[IR_WIDTH-1-IR_OPW -: IR_ACW];
  assign fields.ind = word[IR_WIDTH-1-IR_IND_OFS];
  assign fields.xr  = word[IR_WIDTH-2-IR_IND_OFS -: IR_XRW];
  assign fields.y   = word[IR_YW-1:0];

endmodule

// File: rtl/ir_queue.sv
// Instruction register queue: DEPTH-entry circular buffer of instruction
// words with decoded head fields for the microsequencer.
// Optional same-cycle dbus bypass into an empty queue: define IR_QUEUE_BYPASS_EN.
module ir_queue
  import ks10_ir_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = IR_WIDTH,
  parameter int OPW   = IR_OPW,
  parameter int ACW   = IR_ACW,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int YW   = WIDTH - (OPW + ACW + 5)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clken,
  input  logic             load,
  input  logic [WIDTH-1:0] dbus,
  input  logic             adv,
  input  logic             flush,
  output logic             full,
  output logic             valid,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic [OPW-1:0]   ir,
  output logic [ACW-1:0]   ac,
  output logic             ind,
  output logic [3:0]       xr,
  output logic [YW-1:0]    y
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             ovf_q;

  logic             head_valid;
  logic             bypass_hit;
  logic             bypass_take;
  logic             load_ok;
  logic             adv_store;
  logic             ovf_set;
  logic [CW-1:0]    count_nxt;
  ir_fields_t       head_fields;
  ir_fields_t       sel_fields;

  // Occupancy is tracked only by count; pointers never decide full/empty.
  assign head_valid = (count != '0);
  assign full       = (count == CW'(DEPTH));

`ifdef IR_QUEUE_BYPASS_EN
  ir_fields_t bus_fields;

  assign bypass_hit = ~head_valid & load & clken & ~flush;

  ir_field_split u_split_bus (
    .word   (dbus),
    .fields (bus_fields)
  );
`else
  assign bypass_hit = 1'b0;
`endif

  assign valid = head_valid | bypass_hit;

  // A bypassed word that is consumed in the same cycle never enters storage.
  assign bypass_take = bypass_hit & adv;
  assign adv_store   = adv & head_valid;
  // When full, a simultaneous adv frees the head slot, which wr_ptr aliases.
  assign load_ok     = load & (~full | adv) & ~bypass_take;
  assign ovf_set     = load & full & ~adv;
  assign count_nxt   = count + CW'(load_ok) - CW'(adv_store);

  ir_field_split u_split_head (
    .word   (mem[rd_ptr]),
    .fields (head_fields)
  );

  // Select the field source and blank everything when nothing is presented.
  always_comb begin
    sel_fields = '0;
    if (head_valid) begin
      sel_fields = head_fields;
    end
`ifdef IR_QUEUE_BYPASS_EN
    else if (bypass_hit) begin
      sel_fields = bus_fields;
    end
`endif
  end

  assign ir  = sel_fields.op;
  assign ac  = sel_fields.ac;
  assign ind = sel_fields.ind;
  assign xr  = sel_fields.xr;
  assign y   = sel_fields.y;
  assign ovf = ovf_q;

  // Pointer, count and sticky overflow state; flush wins over load/adv.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else if (clken) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (load_ok)   wr_ptr <= wr_ptr + PW'(1);
        if (adv_store) rd_ptr <= rd_ptr + PW'(1);
        count <= count_nxt;
        if (ovf_set)   ovf_q <= 1'b1;
      end
    end
  end

  // Storage array; contents need no reset since count qualifies every read.
  always_ff @(posedge clk) begin
    if (~rst & clken & ~flush & load_ok) begin
      mem[wr_ptr] <= dbus;
    end
  end

endmodule

// File: tb/tb_ir_queue.sv
// Directed self-checking bench for ir_queue (DEPTH=4, 36-bit words).
module tb_ir_queue;
  import ks10_ir_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clken, load, adv, flush;
  logic [35:0] dbus;
  logic        full, valid, ovf, ind;
  logic [2:0]  count;
  logic [8:0]  ir;
  logic [3:0]  ac, xr;
  logic [17:0] y;

  int checks   = 0;
  int failures = 0;

  ir_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clken(clken), .load(load), .dbus(dbus),
    .adv(adv), .flush(flush), .full(full), .valid(valid), .count(count),
    .ovf(ovf), .ir(ir), .ac(ac), .ind(ind), .xr(xr), .y(y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] wd(input int k);
    return {9'(k), 4'(k), 1'b1, 4'(k), 18'(k)};
  endfunction

  logic [35:0] w0;

  initial begin
    rst = 1'b1; clken = 1'b1; load = 1'b0; adv = 1'b0; flush = 1'b0; dbus = '0;
    w0 = {9'o254, 4'd0, 1'b0, 4'd0, 18'o1000};

    // 1: reset
    step(); step();
    chk("rst_count", count, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ovf",   ovf,   0);
    chk("rst_full",  full,  0);
    chk("rst_ir",    ir,    0);
    chk("rst_ac",    ac,    0);
    chk("rst_y",     y,     0);
    rst = 1'b0;

    // 2: first load into empty queue
    load = 1'b1; dbus = w0;
    #1;
`ifdef IR_QUEUE_BYPASS_EN
    chk("byp_valid", valid, 1);
    chk("byp_ir",    ir,    9'o254);
    chk("byp_y",     y,     18'o1000);
`else
    chk("lat_valid", valid, 0);
    chk("lat_ir",    ir,    0);
`endif
    step();
    load = 1'b0;
    #1;
    chk("ld_valid", valid, 1);
    chk("ld_count", count, 1);
    chk("ld_ir",    ir,    9'o254);
    chk("ld_ac",    ac,    0);
    chk("ld_ind",   ind,   0);
    chk("ld_xr",    xr,    0);
    chk("ld_y",     y,     18'o1000);
    adv = 1'b1; step(); adv = 1'b0;
    chk("adv_empty_count", count, 0);
    chk("adv_empty_valid", valid, 0);

    // 3: fill, overflow, drain in order
    for (int k = 1; k <= 4; k++) begin
      load = 1'b1; dbus = wd(k); step();
    end
    chk("fill_full",  full,  1);
    chk("fill_count", count, 4);
    dbus = wd(5); step(); load = 1'b0;
    chk("ovf_set",   ovf,   1);
    chk("ovf_count", count, 4);
    chk("ovf_head",  ir,    1);
    for (int k = 1; k <= 4; k++) begin
      chk("drain_ir", ir, k);
      chk("drain_y",  y,  k);
      adv = 1'b1; step(); adv = 1'b0;
    end
    chk("drain_count", count, 0);
    chk("drain_valid", valid, 0);
    chk("ovf_sticky",  ovf,   1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_ovf", ovf, 0);

    // adv on empty is ignored
    adv = 1'b1; step(); adv = 1'b0;
    chk("adv_idle_count", count, 0);

    // 4: load+adv while full, wrap
    for (int k = 1; k <= 4; k++) begin
      load = 1'b1; dbus = wd(k); step();
    end
    dbus = wd(5); adv = 1'b1; step(); load = 1'b0; adv = 1'b0;
    chk("la_count", count, 4);
    chk("la_ovf",   ovf,   0);
    chk("la_full",  full,  1);
    for (int k = 2; k <= 5; k++) begin
      chk("wrap_ir", ir, k);
      chk("wrap_ac", ac, k);
      adv = 1'b1; step(); adv = 1'b0;
    end
    chk("wrap_count", count, 0);

    // 5: flush beats load and adv
    for (int k = 6; k <= 8; k++) begin
      load = 1'b1; dbus = wd(k); step();
    end
    chk("pre_flush_count", count, 3);
    dbus = wd(9); adv = 1'b1; flush = 1'b1; step();
    load = 1'b0; adv = 1'b0; flush = 1'b0;
    chk("fl_count", count, 0);
    chk("fl_valid", valid, 0);
    chk("fl_ovf",   ovf,   0);
    chk("fl_ir",    ir,    0);
    chk("fl_y",     y,     0);

    // 6: clken low holds state; reset still works
    for (int k = 10; k <= 11; k++) begin
      load = 1'b1; dbus = wd(k); step();
    end
    clken = 1'b0; dbus = wd(12); adv = 1'b1;
    step(); step(); step();
    chk("hold_count", count, 2);
    chk("hold_ir",    ir,    10);
    chk("hold_valid", valid, 1);
    clken = 1'b1; load = 1'b0; step(); adv = 1'b0;
    chk("resume_ir",    ir,    11);
    chk("resume_count", count, 1);
    clken = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    chk("rst_noclken_count", count, 0);
    chk("rst_noclken_valid", valid, 0);
    chk("rst_noclken_ir",    ir,    0);
    clken = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
